qed_duplicator: RTL and testbench

- Generates the QED (EDDI-V) instruction stream for the mriscvcore formal harness.
- Original instructions from the fetch side pass through unchanged. Each legal original is queued in register-remapped form and later replayed as its duplicate.
- The emitted stream satisfies by construction the pairing constraints the QED checker places on original/duplicate pairs: identical opcode, funct3, funct7 and imm; rd/rs1/rs2 register-mapped.
- Sits between the instruction source and the core's instruction input.

---
 rtl/qed_duplicator.sv | 149 ++++++++++++++
 tb/tb_qed_duplicator.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qed_duplicator.sv
// QED (EDDI-V) instruction stream generator: passes originals through, queues
// register-remapped copies of legal ones and replays them as duplicates.
module qed_duplicator #(
    parameter int unsigned DEPTH    = 8,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  ifu_inst,
    input  logic                         ifu_valid,
    output logic                         ifu_ready,
    input  logic                         dup_req,
    output logic [31:0]                  qed_inst,
    output logic                         qed_valid,
    input  logic                         qed_ready,
    output logic                         qed_is_dup,
    output logic                         qed_illegal,
    output logic                         qed_mode,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic {ORIG = 1'b0, DUP = 1'b1} state_t;

    state_t         state, state_nx;
    logic           dup_pending, pending_nx;
    logic [31:0]    mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           out_free, accept, legal, push, pop, fifo_full, fifo_empty;

    function automatic logic [4:0] map_reg(input logic [4:0] r);
        logic [5:0] t;
        if (r == 5'd0)
            return 5'd0;
        else if (r <= 5'd12)
            return 5'd13 - r;
        t = 6'd44 - {1'b0, r};
        return t[4:0];
    endfunction

    function automatic logic is_legal(input logic [31:0] inst);
        logic [6:0] f7;
        logic [2:0] f3;
        f7 = inst[31:25];
        f3 = inst[14:12];
        case (inst[6:0])
            OPC_OP:
                return (f7 == 7'b0) ||
                       (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
            OPC_OP_IMM:
                case (f3)
                    3'b001:  return f7 == 7'b0;
                    3'b101:  return f7 == 7'b0 || f7 == 7'b0100000;
                    default: return 1'b1;
                endcase
            default:
                return 1'b0;
        endcase
    endfunction

    // rs2 field is immediate for OP_IMM, so it is remapped only for OP
    function automatic logic [31:0] remap(input logic [31:0] inst);
        logic [31:0] r;
        r        = inst;
        r[11:7]  = map_reg(inst[11:7]);
        r[19:15] = map_reg(inst[19:15]);
        if (inst[6:0] == OPC_OP)
            r[24:20] = map_reg(inst[24:20]);
        return r;
    endfunction

    assign fifo_full  = (fifo_count == CW'(DEPTH));
    assign fifo_empty = (fifo_count == '0);
    assign out_free   = !qed_valid || qed_ready;
    assign ifu_ready  = (state == ORIG) && out_free && !fifo_full && !dup_pending;
    assign accept     = ifu_valid && ifu_ready;
    assign legal      = is_legal(ifu_inst);
    assign push       = accept && legal;
    assign pop        = (state == DUP) && out_free && !fifo_empty;
    assign qed_mode   = (state == DUP);

    always_comb begin
        state_nx   = state;
        pending_nx = dup_pending;
        case (state)
            ORIG: begin
                if (dup_req && (!fifo_empty || push))
                    pending_nx = 1'b1;
                if (!fifo_empty && (dup_pending || fifo_full)) begin
                    state_nx   = DUP;
                    pending_nx = 1'b0;
                end
            end
            DUP: begin
                if (pop && fifo_count == CW'(1))
                    state_nx = ORIG;
            end
            default: state_nx = ORIG;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= remap(ifu_inst);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ORIG;
            dup_pending <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            qed_inst    <= '0;
            qed_valid   <= 1'b0;
            qed_is_dup  <= 1'b0;
            qed_illegal <= 1'b0;
        end else begin
            state       <= state_nx;
            dup_pending <= pending_nx;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                fifo_count <= fifo_count + CW'(1);
            else if (pop && !push)
                fifo_count <= fifo_count - CW'(1);
            if (accept) begin
                qed_inst    <= legal ? ifu_inst : NOP_INST;
                qed_valid   <= 1'b1;
                qed_is_dup  <= 1'b0;
                qed_illegal <= !legal;
            end else if (pop) begin
                qed_inst    <= mem[rd_ptr];
                qed_valid   <= 1'b1;
                qed_is_dup  <= 1'b1;
                qed_illegal <= 1'b0;
            end else if (out_free) begin
                qed_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_qed_duplicator.sv
// Randomized scoreboard bench for qed_duplicator with directed scenarios.
module tb_qed_duplicator;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] ifu_inst = '0;
    logic        ifu_valid = 1'b0;
    logic        ifu_ready;
    logic        dup_req = 1'b0;
    logic [31:0] qed_inst;
    logic        qed_valid;
    logic        qed_ready = 1'b1;
    logic        qed_is_dup;
    logic        qed_illegal;
    logic        qed_mode;
    logic [2:0]  fifo_count;

    qed_duplicator #(.DEPTH(DEPTH), .NOP_INST(NOP_INST)) dut (
        .clk(clk), .rst(rst),
        .ifu_inst(ifu_inst), .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
        .dup_req(dup_req),
        .qed_inst(qed_inst), .qed_valid(qed_valid), .qed_ready(qed_ready),
        .qed_is_dup(qed_is_dup), .qed_illegal(qed_illegal),
        .qed_mode(qed_mode), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic        dup;
        logic        ill;
    } exp_t;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model: pending duplicates and expected output stream
    logic [31:0] dupq [$];
    exp_t        expq [$];
    bit          mode_m = 1'b0;
    bit          pend_m = 1'b0;
    bit          ov_m   = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [4:0] tb_map(int unsigned n);
        if (n == 0)  return 5'd0;
        if (n <= 12) return 5'(13 - n);
        return 5'(44 - n);
    endfunction

    function automatic bit tb_legal(logic [31:0] i);
        int unsigned op = i[6:0];
        int unsigned f3 = i[14:12];
        int unsigned f7 = i[31:25];
        if (op == 'h33) return f7 == 0 || (f7 == 32 && (f3 == 0 || f3 == 5));
        if (op == 'h13) begin
            if (f3 == 1) return f7 == 0;
            if (f3 == 5) return f7 == 0 || f7 == 32;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [31:0] tb_dup(logic [31:0] i);
        logic [31:0] d = i;
        d[11:7]  = tb_map(i[11:7]);
        d[19:15] = tb_map(i[19:15]);
        if (i[6:0] == 7'h33) d[24:20] = tb_map(i[24:20]);
        return d;
    endfunction

    function automatic logic [31:0] gen_inst();
        logic [31:0] r = $urandom;
        case ($urandom_range(0, 4))
            0: begin
                r[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0;
                if ($urandom_range(0, 5) == 0) r[31:25] = 7'($urandom);
                r[6:0] = 7'h33;
            end
            1: r[6:0] = 7'h13;
            2: begin
                r[6:0]   = 7'h13;
                r[13:12] = 2'b01;
                case ($urandom_range(0, 2))
                    0: r[31:25] = 7'b0;
                    1: r[31:25] = 7'b0100000;
                    default: ;
                endcase
            end
            3: r[6:0] = 7'h03;
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin : model
        bit fr, acc, pushed, lg, pend_old;
        int unsigned sz;
        if (rst) begin
            mode_m = 1'b0; pend_m = 1'b0; ov_m = 1'b0;
            dupq.delete(); expq.delete();
        end else begin
            fr = !ov_m || qed_ready;
            sz = dupq.size();
            pend_old = pend_m;
            if (!mode_m) begin
                acc = ifu_valid && fr && sz < DEPTH && !pend_m;
                pushed = 1'b0;
                if (acc) begin
                    lg = tb_legal(ifu_inst);
                    expq.push_back({lg ? ifu_inst : NOP_INST, 1'b0, !lg});
                    if (lg) begin
                        dupq.push_back(tb_dup(ifu_inst));
                        pushed = 1'b1;
                    end
                    ov_m = 1'b1;
                end else if (fr) begin
                    ov_m = 1'b0;
                end
                if (dup_req && (sz > 0 || pushed)) pend_m = 1'b1;
                if (sz > 0 && (pend_old || sz == DEPTH)) begin
                    mode_m = 1'b1;
                    pend_m = 1'b0;
                end
            end else if (fr) begin
                if (sz > 0) begin
                    expq.push_back({dupq.pop_front(), 1'b1, 1'b0});
                    ov_m = 1'b1;
                    if (dupq.size() == 0) mode_m = 1'b0;
                end else begin
                    ov_m = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin : monitor
        exp_t e;
        if (chk_en && !rst && qed_valid && qed_ready) begin
            if (expq.size() == 0) begin
                chk("sb_unexpected_output", qed_inst, 32'hxxxx_xxxx);
            end else begin
                e = expq.pop_front();
                chk("sb_inst", qed_inst, e.inst);
                chk("sb_is_dup", 32'(qed_is_dup), 32'(e.dup));
                chk("sb_illegal", 32'(qed_illegal), 32'(e.ill));
            end
        end
    end

    always @(negedge clk) begin : cycle_check
        #2;
        if (chk_en) begin
            chk("ifu_ready", 32'(ifu_ready),
                32'(!mode_m && (!ov_m || qed_ready) && dupq.size() < DEPTH && !pend_m));
            chk("qed_valid", 32'(qed_valid), 32'(ov_m));
            chk("qed_mode", 32'(qed_mode), 32'(mode_m));
            chk("fifo_count", 32'(fifo_count), 32'(dupq.size()));
        end
    end

    task automatic sync();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_out(string name, logic [31:0] inst, bit dup, bit ill);
        bit found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            #2;
            if (qed_valid && qed_is_dup == dup) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            chk(name, qed_inst, inst);
            chk({name, "_ill"}, 32'(qed_illegal), 32'(ill));
        end
    endtask

    task automatic issue(logic [31:0] inst);
        sync();
        ifu_valid = 1'b1;
        ifu_inst  = inst;
    endtask

    task automatic wait_mode_count(bit m, int unsigned c, string name);
        bit found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #2;
            if (qed_mode == m && fifo_count == 3'(c)) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [31:0] ops [4];
        logic [31:0] held_inst;
        logic        held_dup;
        logic [2:0]  held_cnt;

        repeat (3) @(negedge clk);
        #2;
        chk("rst_qed_valid", 32'(qed_valid), 32'd0);
        chk("rst_qed_inst", qed_inst, 32'd0);
        chk("rst_is_dup", 32'(qed_is_dup), 32'd0);
        chk("rst_illegal", 32'(qed_illegal), 32'd0);
        chk("rst_mode", 32'(qed_mode), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk_en = 1'b1;
        sync();
        rst = 1'b0;

        // ADD x3,x1,x2 followed by dup request
        issue(32'h002081B3);
        sync();
        ifu_valid = 1'b0;
        dup_req   = 1'b1;
        #1;
        chk("add_orig", qed_inst, 32'h002081B3);
        chk("add_orig_dup", 32'(qed_is_dup), 32'd0);
        sync();
        dup_req = 1'b0;
        wait_out("add_dup", 32'h00B60533, 1'b1, 1'b0);
        chk("add_mode_back", 32'(qed_mode), 32'd0);

        // ADDI x5,x0,7: immediate bits in rs2 field must not be remapped
        issue(32'h00700293);
        sync();
        ifu_valid = 1'b0;
        dup_req   = 1'b1;
        sync();
        dup_req = 1'b0;
        wait_out("addi_dup", 32'h00700413, 1'b1, 1'b0);

        // LW is illegal: NOP substitution, nothing queued, dup_req dropped
        issue(32'h0000A083);
        sync();
        ifu_valid = 1'b0;
        dup_req   = 1'b1;
        #1;
        chk("lw_nop", qed_inst, NOP_INST);
        chk("lw_illegal", 32'(qed_illegal), 32'd1);
        sync();
        dup_req = 1'b0;
        #1;
        chk("lw_count", 32'(fifo_count), 32'd0);
        repeat (3) sync();
        #1;
        chk("lw_mode", 32'(qed_mode), 32'd0);

        // Fill to DEPTH without dup_req: automatic replay
        ops[0] = 32'h002081B3; ops[1] = 32'h40418233;
        ops[2] = 32'h00F6D5B3; ops[3] = 32'h01FF0EB3;
        for (int k = 0; k < 4; k++) issue(ops[k]);
        sync();
        ifu_valid = 1'b0;
        #1;
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ready", 32'(ifu_ready), 32'd0);
        sync();
        #1;
        chk("full_auto_dup", 32'(qed_mode), 32'd1);
        for (int k = 0; k < 4; k++) wait_out("full_dup_order", tb_dup(ops[k]), 1'b1, 1'b0);
        chk("full_after_count", 32'(fifo_count), 32'd0);

        // Back-pressure during replay
        for (int k = 0; k < 3; k++) issue(ops[k]);
        sync();
        ifu_valid = 1'b0;
        dup_req   = 1'b1;
        sync();
        dup_req = 1'b0;
        wait_out("stall_dup0", tb_dup(ops[0]), 1'b1, 1'b0);
        qed_ready = 1'b0;
        held_inst = qed_inst;
        held_dup  = qed_is_dup;
        held_cnt  = fifo_count;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #2;
            chk("stall_inst", qed_inst, held_inst);
            chk("stall_is_dup", 32'(qed_is_dup), 32'(held_dup));
            chk("stall_count", 32'(fifo_count), 32'(held_cnt));
        end
        qed_ready = 1'b1;
        wait_out("stall_dup1", tb_dup(ops[1]), 1'b1, 1'b0);
        wait_out("stall_dup2", tb_dup(ops[2]), 1'b1, 1'b0);

        // Reset mid-replay with two entries left
        for (int k = 0; k < 3; k++) issue(ops[k]);
        sync();
        ifu_valid = 1'b0;
        dup_req   = 1'b1;
        sync();
        dup_req = 1'b0;
        wait_mode_count(1'b1, 2, "mid_rst_setup");
        rst = 1'b1;
        sync();
        rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(qed_valid), 32'd0);
        chk("mid_rst_count", 32'(fifo_count), 32'd0);
        chk("mid_rst_mode", 32'(qed_mode), 32'd0);
        chk("mid_rst_ready", 32'(ifu_ready), 32'd1);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            sync();
            ifu_valid = ($urandom_range(0, 3) != 0);
            ifu_inst  = gen_inst();
            qed_ready = ($urandom_range(0, 3) != 0);
            dup_req   = ($urandom_range(0, 11) == 0);
        end

        // Drain
        sync();
        ifu_valid = 1'b0;
        qed_ready = 1'b1;
        dup_req   = 1'b0;
        for (int c = 0; c < 100; c++) begin
            sync();
            dup_req = (fifo_count != '0);
            #1;
            if (fifo_count == '0 && !qed_mode && !qed_valid) break;
        end
        dup_req = 1'b0;
        sync();
        chk("drain_expq_empty", 32'(expq.size()), 32'd0);
        chk("drain_dupq_empty", 32'(dupq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
